// File: rtl/vga_pixel_pipe_if.sv
// Capture-RAM read port: vga_pixel_pipe drives address/strobe (master), the RAM returns palette indices (slave).
interface vga_pixel_pipe_if #(
   parameter int ADDR_W = 18
) ();
   logic [ADDR_W-1:0] RAM_ADDR;
   logic              RAM_RD;
   logic [3:0]        RAM_DATA;

   modport master (output RAM_ADDR, output RAM_RD, input RAM_DATA);
   modport slave  (input RAM_ADDR, input RAM_RD, output RAM_DATA);
endinterface

// File: rtl/vga_pixel_pipe.sv
// Pixel-fetch stage: timing-generator coordinates -> capture-RAM reads -> palette RGB, syncs/DE delay-matched.
// Optional macro VGA_PIXEL_PIPE_TESTPAT_EN: 8 vertical colour bars on DE pixels while ENABLE is low.
module vga_pixel_pipe #(
   parameter int          SRC_W       = 512,
   parameter int          SRC_H       = 300,
   parameter int          SCALE_SHIFT = 1,
   parameter int          RAM_LAT     = 2,
   parameter int          ADDR_W      = 18,
   parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
   input  logic                    VIDEO_CLK,
   input  logic                    RESET,
   input  logic                    ENABLE,
   input  logic [11:0]             VGA_X_I,
   input  logic [11:0]             VGA_Y_I,
   input  logic                    VGA_VISIBLE_I,
   input  logic                    VGA_HS_I,
   input  logic                    VGA_VS_I,
   vga_pixel_pipe_if.master        ram,
   input  logic                    PAL_WE,
   input  logic [3:0]              PAL_ADDR,
   input  logic [23:0]             PAL_DATA,
   output logic [7:0]              VGA_RED,
   output logic [7:0]              VGA_GREEN,
   output logic [7:0]              VGA_BLUE,
   output logic                    VGA_HS,
   output logic                    VGA_VS,
   output logic                    VGA_DE
);
   localparam int                L        = RAM_LAT + 2;
   localparam logic [12:0]       SRC_W_C  = 13'(SRC_W);
   localparam logic [12:0]       SRC_H_C  = 13'(SRC_H);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

   // 17*i for a 4-bit i is the nibble repeated, giving the greyscale ramp.
   function automatic logic [23:0] grey_rgb(input logic [3:0] idx);
      return {3{idx, idx}};
   endfunction

   logic [11:0]       x_q, y_q, last_sy_q, last_sy_d, sx_s, sy_s;
   logic              vis_q, hs_q, vs_q, en_q, vis_p_q, vs_p_q, in_img_s;
   logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
   logic              rd_q, rd_d;
   logic [L-1:0]      hs_dly_q, vs_dly_q, de_dly_q, img_dly_q, en_dly_q;
   logic [23:0]       pal_q [16];
   logic [23:0]       rgb_q, rgb_d;
`ifdef VGA_PIXEL_PIPE_TESTPAT_EN
   logic [2:0]        bar_dly_q [L];
`endif

   assign sx_s     = x_q >> SCALE_SHIFT;
   assign sy_s     = y_q >> SCALE_SHIFT;
   assign in_img_s = vis_q & ({1'b0, sx_s} < SRC_W_C) & ({1'b0, sy_s} < SRC_H_C);

   // Stage 0: register every timing input plus one-cycle history for edge detection.
   always_ff @(posedge VIDEO_CLK) begin
      if (RESET) begin
         x_q     <= 12'd0;
         y_q     <= 12'd0;
         vis_q   <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b0;
         en_q    <= 1'b0;
         vis_p_q <= 1'b0;
         vs_p_q  <= 1'b0;
      end else begin
         x_q     <= VGA_X_I;
         y_q     <= VGA_Y_I;
         vis_q   <= VGA_VISIBLE_I;
         hs_q    <= VGA_HS_I;
         vs_q    <= VGA_VS_I;
         en_q    <= ENABLE;
         vis_p_q <= vis_q;
         vs_p_q  <= vs_q;
      end
   end

   // Row base steps by SRC_W once per new source row; the first pixel of the line already uses the new base.
   always_comb begin
      row_base_d = row_base_q;
      last_sy_d  = last_sy_q;
      if (vs_q && !vs_p_q) begin
         row_base_d = {ADDR_W{1'b0}};
         last_sy_d  = 12'd0;
      end else if (vis_q && !vis_p_q && (sy_s != last_sy_q)) begin
         row_base_d = row_base_q + ROW_STEP;
         last_sy_d  = sy_s;
      end else begin
         row_base_d = row_base_q;
         last_sy_d  = last_sy_q;
      end
      rd_d = in_img_s & en_q;
      if (rd_d) begin
         addr_d = row_base_d + ADDR_W'(sx_s);
      end else begin
         addr_d = addr_q;
      end
   end

   // Stage 1: RAM request registers and row tracking.
   always_ff @(posedge VIDEO_CLK) begin
      if (RESET) begin
         row_base_q <= {ADDR_W{1'b0}};
         last_sy_q  <= 12'd0;
         addr_q     <= {ADDR_W{1'b0}};
         rd_q       <= 1'b0;
      end else begin
         row_base_q <= row_base_d;
         last_sy_q  <= last_sy_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
      end
   end

   // Delay line carrying syncs and per-pixel flags alongside the RAM access.
   always_ff @(posedge VIDEO_CLK) begin
      if (RESET) begin
         hs_dly_q  <= {L{1'b1}};
         vs_dly_q  <= {L{1'b0}};
         de_dly_q  <= {L{1'b0}};
         img_dly_q <= {L{1'b0}};
         en_dly_q  <= {L{1'b0}};
`ifdef VGA_PIXEL_PIPE_TESTPAT_EN
         for (int k = 0; k < L; k++) bar_dly_q[k] <= 3'd0;
`endif
      end else begin
         hs_dly_q  <= {hs_dly_q[L-2:0], hs_q};
         vs_dly_q  <= {vs_dly_q[L-2:0], vs_q};
         de_dly_q  <= {de_dly_q[L-2:0], vis_q};
         img_dly_q <= {img_dly_q[L-2:0], in_img_s};
         en_dly_q  <= {en_dly_q[L-2:0], en_q};
`ifdef VGA_PIXEL_PIPE_TESTPAT_EN
         bar_dly_q[0] <= x_q[9:7];
         for (int k = 1; k < L; k++) bar_dly_q[k] <= bar_dly_q[k-1];
`endif
      end
   end

   // Flags at index L-2 line up with RAM_DATA for the same pixel.
   always_comb begin
      rgb_d = 24'h000000;
      if (!de_dly_q[L-2]) begin
         rgb_d = 24'h000000;
      end else if (!en_dly_q[L-2]) begin
`ifdef VGA_PIXEL_PIPE_TESTPAT_EN
         rgb_d = {{8{bar_dly_q[L-2][2]}}, {8{bar_dly_q[L-2][1]}}, {8{bar_dly_q[L-2][0]}}};
`else
         rgb_d = 24'h000000;
`endif
      end else if (!img_dly_q[L-2]) begin
         rgb_d = BORDER_RGB;
      end else begin
         rgb_d = pal_q[ram.RAM_DATA];
      end
   end

   // Palette register file and registered colour output.
   always_ff @(posedge VIDEO_CLK) begin
      if (RESET) begin
         for (int i = 0; i < 16; i++) pal_q[i] <= grey_rgb(4'(i));
         rgb_q <= 24'h000000;
      end else begin
         if (PAL_WE) begin
            pal_q[PAL_ADDR] <= PAL_DATA;
         end
         rgb_q <= rgb_d;
      end
   end

   assign ram.RAM_ADDR = addr_q;
   assign ram.RAM_RD   = rd_q;
   assign VGA_RED      = rgb_q[23:16];
   assign VGA_GREEN    = rgb_q[15:8];
   assign VGA_BLUE     = rgb_q[7:0];
   assign VGA_HS       = hs_dly_q[L-1];
   assign VGA_VS       = vs_dly_q[L-1];
   assign VGA_DE       = de_dly_q[L-1];
endmodule
